// File: rtl/alu8_pkg.sv
// alu8_pkg: opcode constants and flag-bit indices shared by the CPU decoder
// and the ALU.
//   OP_*       5-bit operation codes
//   FLAG_*     bit positions of carry/zero/sign in the packed flag vector
package alu8_pkg;

   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
   localparam logic [OP_W-1:0] OP_ADC  = 5'b00010;
   localparam logic [OP_W-1:0] OP_SBC  = 5'b00011;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00100;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00101;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b00110;
   localparam logic [OP_W-1:0] OP_XOR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_INC  = 5'b01000;
   localparam logic [OP_W-1:0] OP_DEC  = 5'b01001;
   localparam logic [OP_W-1:0] OP_CMP  = 5'b01010;
   localparam logic [OP_W-1:0] OP_TEST = 5'b01011;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b10000;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b10001;
   localparam logic [OP_W-1:0] OP_SAL  = 5'b10010;
   localparam logic [OP_W-1:0] OP_SAR  = 5'b10011;
   localparam logic [OP_W-1:0] OP_ROL  = 5'b10100;
   localparam logic [OP_W-1:0] OP_ROR  = 5'b10101;
   localparam logic [OP_W-1:0] OP_RCL  = 5'b10110;
   localparam logic [OP_W-1:0] OP_RCR  = 5'b10111;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_S = 2;
   localparam int FLAG_W = 3;

endpackage

// File: rtl/alu8.sv
// alu8: 8-bit ALU with combinational result and registered C/Z/S flags.
//   clk        clock
//   reset      synchronous, active-high; clears flags
//   en         flag-update strobe for the current operation
//   A, B       operands
//   operation  opcode (see alu8_pkg)
//   result     combinational result, uses registered C as carry-in
//   C, Z, S    registered carry/borrow, zero, sign flags
module alu8
   import alu8_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  operation,
   output logic [WIDTH-1:0] result,
   output logic             C,
   output logic             Z,
   output logic             S
);

   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              cin;
   logic [WIDTH:0]    a_x, b_x, cin_x, one_x;
   logic [WIDTH-1:0]  res;
   logic              c_nx;
   logic              op_valid;

   // carry-in comes only from the flag register, so no combinational loop
   assign cin   = flags_q[FLAG_C];
   assign a_x   = {1'b0, A};
   assign b_x   = {1'b0, B};
   assign cin_x = {{WIDTH{1'b0}}, cin};
   assign one_x = {{WIDTH{1'b0}}, 1'b1};

   // subtraction in WIDTH+1 bits leaves the borrow in the top bit
   always_comb begin
      res      = A;
      c_nx     = 1'b0;
      op_valid = 1'b1;
      case (operation)
         OP_ADD:          {c_nx, res} = a_x + b_x;
         OP_SUB, OP_CMP:  {c_nx, res} = a_x - b_x;
         OP_ADC:          {c_nx, res} = a_x + b_x + cin_x;
         OP_SBC:          {c_nx, res} = a_x - b_x - cin_x;
         OP_AND, OP_TEST: res = A & B;
         OP_OR:           res = A | B;
         OP_NOT:          res = ~B;
         OP_XOR:          res = A ^ B;
         OP_INC:          {c_nx, res} = b_x + one_x;
         OP_DEC:          {c_nx, res} = b_x - one_x;
         OP_SHL, OP_SAL: begin
            res  = {A[WIDTH-2:0], 1'b0};
            c_nx = A[WIDTH-1];
         end
         OP_SHR: begin
            res  = {1'b0, A[WIDTH-1:1]};
            c_nx = A[0];
         end
         OP_SAR: begin
            res  = {A[WIDTH-1], A[WIDTH-1:1]};
            c_nx = A[0];
         end
         OP_ROL: begin
            res  = {A[WIDTH-2:0], A[WIDTH-1]};
            c_nx = A[WIDTH-1];
         end
         OP_ROR: begin
            res  = {A[0], A[WIDTH-1:1]};
            c_nx = A[0];
         end
         OP_RCL: begin
            res  = {A[WIDTH-2:0], cin};
            c_nx = A[WIDTH-1];
         end
         OP_RCR: begin
            res  = {cin, A[WIDTH-1:1]};
            c_nx = A[0];
         end
         default: begin
            res      = A;
            op_valid = 1'b0;
         end
      endcase
   end

   always_comb begin
      flags_d = flags_q;
      if (en && op_valid) begin
         flags_d[FLAG_C] = c_nx;
         flags_d[FLAG_Z] = (res == '0);
         flags_d[FLAG_S] = res[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign result = res;
   assign C      = flags_q[FLAG_C];
   assign Z      = flags_q[FLAG_Z];
   assign S      = flags_q[FLAG_S];

endmodule

// File: tb/tb_alu8.sv
// tb_alu8: directed vectors with literal expectations plus a behavioural
// model compared against the DUT every negative clock edge.
module tb_alu8;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] a_s, b_s;
   logic [4:0] op_s;
   logic [7:0] result;
   logic       C, Z, S;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   int m_c = 0, m_z = 0, m_s = 0;

   alu8 #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .A         (a_s),
      .B         (b_s),
      .operation (op_s),
      .result    (result),
      .C         (C),
      .Z         (Z),
      .S         (S)
   );

   always #5 clk = ~clk;

   // model in plain integer arithmetic
   function automatic void model(input int op, input int a, input int b, input int cin,
                                 output int r, output int c, output int def);
      int s;
      def = 1; c = 0; r = a;
      case (op)
         0, 10: begin s = a - b; r = (s + 256) % 256; c = (a < b) ? 1 : 0; end
         default: def = 0;
      endcase
      case (op)
         0:  begin s = a + b; r = s % 256; c = (s > 255) ? 1 : 0; end
         1:  begin s = a - b; r = (s + 256) % 256; c = (a < b) ? 1 : 0; end
         2:  begin s = a + b + cin; r = s % 256; c = (s > 255) ? 1 : 0; end
         3:  begin s = a - b - cin; r = (s + 512) % 256; c = (s < 0) ? 1 : 0; end
         4, 11: begin r = a & b; def = 1; end
         5:  begin r = a | b; def = 1; end
         6:  begin r = 255 - b; def = 1; end
         7:  begin r = a ^ b; def = 1; end
         8:  begin r = (b + 1) % 256; c = (b == 255) ? 1 : 0; end
         9:  begin r = (b + 255) % 256; c = (b == 0) ? 1 : 0; end
         16, 18: begin r = (a * 2) % 256; c = a / 128; end
         17: begin r = a / 2; c = a % 2; end
         19: begin r = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; end
         20: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
         21: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
         22: begin r = (a * 2) % 256 + cin; c = a / 128; end
         23: begin r = a / 2 + cin * 128; c = a % 2; end
         default: ;
      endcase
      if (op inside {[0:3], [8:10], [16:23]}) def = 1;
   endfunction

   always @(posedge clk) begin
      int r, c, d;
      if (reset) begin
         m_c = 0; m_z = 0; m_s = 0;
      end else if (en) begin
         model(int'(op_s), int'(a_s), int'(b_s), m_c, r, c, d);
         if (d != 0) begin
            m_c = c; m_z = (r == 0) ? 1 : 0; m_s = (r >= 128) ? 1 : 0;
         end
      end
   end

   always @(negedge clk) begin
      int r, c, d;
      if (chk_on) begin
         model(int'(op_s), int'(a_s), int'(b_s), m_c, r, c, d);
         n_cmp++;
         if (int'(result) != r || int'(C) != m_c || int'(Z) != m_z || int'(S) != m_s) begin
            n_err++;
            $display("FAIL model op=%0d A=%02h B=%02h: got r=%02h C%0b Z%0b S%0b, want r=%02h C%0d Z%0d S%0d",
                     op_s, a_s, b_s, result, C, Z, S, r, m_c, m_z, m_s);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic e);
      @(negedge clk);
      #1;
      op_s = op; a_s = a; b_s = b; en = e;
      #1;
   endtask

   // one-cycle en pulse; returns the result seen before the edge
   task automatic pulse(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r);
      drive(op, a, b, 1'b1);
      r = result;
      @(negedge clk);
      #1;
      en = 1'b0;
      #1;
   endtask

   task automatic flags(input string name, input int c, input int z, input int s);
      check({name, ".C"}, int'(C), c);
      check({name, ".Z"}, int'(Z), z);
      check({name, ".S"}, int'(S), s);
   endtask

   logic [7:0] r;
   logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h81, 8'h7F};
   logic [7:0] vb [4] = '{8'h01, 8'hFF, 8'h00, 8'h80};

   initial begin
      reset = 1'b1; en = 1'b0; op_s = 5'd0; a_s = 8'h00; b_s = 8'h00;
      @(negedge clk);
      @(negedge clk);
      #1;
      reset = 1'b0;
      flags("reset", 0, 0, 0);
      chk_on = 1'b1;

      pulse(5'b00000, 8'h7F, 8'h01, r); check("add_7f", int'(r), 'h80);
      flags("add_7f", 0, 0, 1);
      pulse(5'b00000, 8'hFF, 8'h01, r); check("add_ff", int'(r), 'h00);
      flags("add_ff", 1, 1, 0);
      drive(5'b00010, 8'h10, 8'h20, 1'b0); check("adc_cin", int'(result), 'h31);

      pulse(5'b00001, 8'h05, 8'h06, r); check("sub", int'(r), 'hFF);
      flags("sub", 1, 0, 1);
      pulse(5'b01010, 8'h42, 8'h42, r); check("cmp", int'(r), 'h00);
      flags("cmp", 0, 1, 0);

      drive(5'b00100, 8'hF0, 8'h3C, 1'b0); check("and", int'(result), 'h30);
      drive(5'b00101, 8'hF0, 8'h3C, 1'b0); check("or",  int'(result), 'hFC);
      drive(5'b00111, 8'hF0, 8'h3C, 1'b0); check("xor", int'(result), 'hCC);
      pulse(5'b00110, 8'hF0, 8'h3C, r); check("not", int'(r), 'hC3);
      flags("not", 0, 0, 1);
      pulse(5'b01011, 8'h0F, 8'hF0, r); flags("test", 0, 1, 0);

      pulse(5'b01000, 8'h00, 8'hFF, r); check("inc", int'(r), 'h00);
      flags("inc", 1, 1, 0);
      pulse(5'b01001, 8'h00, 8'h00, r); check("dec", int'(r), 'hFF);
      flags("dec", 1, 0, 1);

      pulse(5'b00100, 8'h00, 8'h00, r); flags("clr_c", 0, 1, 0);
      drive(5'b10000, 8'h81, 8'h00, 1'b0); check("shl", int'(result), 'h02);
      drive(5'b10001, 8'h81, 8'h00, 1'b0); check("shr", int'(result), 'h40);
      drive(5'b10011, 8'h81, 8'h00, 1'b0); check("sar", int'(result), 'hC0);
      drive(5'b10100, 8'h81, 8'h00, 1'b0); check("rol", int'(result), 'h03);
      drive(5'b10101, 8'h81, 8'h00, 1'b0); check("ror", int'(result), 'hC0);
      drive(5'b10111, 8'h81, 8'h00, 1'b0); check("rcr_c0", int'(result), 'h40);
      pulse(5'b10000, 8'h81, 8'h00, r); flags("shl", 1, 0, 0);
      drive(5'b10110, 8'h81, 8'h00, 1'b0); check("rcl_c1", int'(result), 'h03);

      drive(5'b00000, 8'hFF, 8'h01, 1'b0);
      drive(5'b00001, 8'h00, 8'h01, 1'b0);
      flags("en0_hold", 1, 0, 0);

      pulse(5'b01100, 8'h00, 8'h55, r); check("undef_res", int'(r), 'h00);
      flags("undef_hold", 1, 0, 0);

      pulse(5'b10001, 8'h81, 8'h00, r); flags("shr", 1, 0, 0);
      pulse(5'b10011, 8'h81, 8'h00, r); flags("sar", 1, 0, 1);

      // en held: ADC chain recomputes with updated carry each cycle
      drive(5'b00010, 8'hFF, 8'h00, 1'b1);
      drive(5'b00010, 8'hFF, 8'h00, 1'b1);
      drive(5'b00011, 8'h00, 8'h00, 1'b1);
      drive(5'b00011, 8'h00, 8'h00, 1'b1);
      drive(5'b10110, 8'hAA, 8'h00, 1'b1);
      drive(5'b10111, 8'h55, 8'h00, 1'b1);
      drive(5'b10111, 8'h55, 8'h00, 1'b0);

      for (int op = 0; op < 32; op++) begin
         for (int k = 0; k < 4; k++) begin
            pulse(5'(op), va[k], vb[k], r);
         end
      end

      @(negedge clk);
      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
